// File: rtl/mask_share_bridge.sv
// Splits plaintext bits into two Boolean shares using LFSR masks, feeds a
// pipelined masked core, and recombines/checks the core's returned shares.
module mask_share_bridge #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned CORE_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    input  logic        reseed_valid,
    input  logic [15:0] reseed_data,
    output logic        a0,
    output logic        a1,
    output logic        b0,
    output logic        b1,
    output logic        c0,
    output logic        c1,
    output logic        d0,
    output logic        d1,
    output logic        r0,
    output logic        r1,
    output logic        r2,
    input  logic        out0,
    input  logic        out1,
    input  logic        out_n0,
    input  logic        out_n1,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_data,
    output logic        res_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [15:0] lfsr;
    logic [3:0]  share0, share1;
    logic [2:0]  rnd;
    logic        accept;
    logic        capture;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign accept  = (state == IDLE) && in_valid;
    assign capture = (state == WAIT) && (cnt == 4'd0);

    // Reseed wins over the free-running step; an all-zero seed would lock up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (reseed_valid) begin
            lfsr <= (reseed_data == 16'h0000) ? LFSR_SEED : reseed_data;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= 4'(CORE_LAT);
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Shares and randomness only change on accept, so the core sees stable inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share0 <= 4'd0;
            share1 <= 4'd0;
            rnd    <= 3'd0;
        end else if (accept) begin
            share0 <= in_data ^ lfsr[3:0];
            share1 <= lfsr[3:0];
            rnd    <= lfsr[6:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= 1'b0;
            res_err  <= 1'b0;
        end else if (capture) begin
            res_data <= out0 ^ out1;
            res_err  <= ~((out0 ^ out1) ^ (out_n0 ^ out_n1));
        end
    end

    assign a0 = share0[0];
    assign a1 = share1[0];
    assign b0 = share0[1];
    assign b1 = share1[1];
    assign c0 = share0[2];
    assign c1 = share1[2];
    assign d0 = share0[3];
    assign d1 = share1[3];
    assign r0 = rnd[0];
    assign r1 = rnd[1];
    assign r2 = rnd[2];

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);

endmodule

// File: tb/tb_mask_share_bridge.sv
// Bench for mask_share_bridge: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mask_share_bridge;

    localparam int          CL   = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        reseed_valid = 1'b0;
    logic [15:0] reseed_data = 16'd0;
    logic        out0 = 1'b0, out1 = 1'b0, out_n0 = 1'b0, out_n1 = 1'b0;
    logic        res_ready = 1'b0;
    logic        in_ready, a0, a1, b0, b1, c0, c1, d0, d1, r0, r1, r2;
    logic        res_valid, res_data, res_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mask_share_bridge #(.LFSR_SEED(SEED), .CORE_LAT(CL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .reseed_valid(reseed_valid), .reseed_data(reseed_data),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0), .c1(c1), .d0(d0), .d1(d1),
        .r0(r0), .r1(r1), .r2(r2),
        .out0(out0), .out1(out1), .out_n0(out_n0), .out_n1(out_n1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] dut_sh();
        return {a0, a1, b0, b1, c0, c1, d0, d1, r0, r1, r2};
    endfunction

    // Transaction-level model: phase 0 = free, 1 = request in flight, 2 = result offered.
    logic [15:0] m_lfsr = SEED;
    int          m_phase = 0;
    int          m_age = 0;
    logic [10:0] m_sh = '0;
    logic        m_data = 1'b0;
    logic        m_err = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_lfsr  <= SEED;
            m_phase <= 0;
            m_age   <= 0;
            m_sh    <= '0;
            m_data  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            if (m_phase == 0 && in_valid) begin
                m_sh <= {in_data[0] ^ m_lfsr[0], m_lfsr[0], in_data[1] ^ m_lfsr[1], m_lfsr[1],
                         in_data[2] ^ m_lfsr[2], m_lfsr[2], in_data[3] ^ m_lfsr[3], m_lfsr[3],
                         m_lfsr[4], m_lfsr[5], m_lfsr[6]};
                m_phase <= 1;
                m_age   <= 0;
            end else if (m_phase == 1) begin
                m_age <= m_age + 1;
                if (m_age + 1 == CL + 1) begin
                    m_data  <= out0 ^ out1;
                    m_err   <= ((out0 ^ out1) == (out_n0 ^ out_n1));
                    m_phase <= 2;
                end
            end else if (m_phase == 2 && res_ready) begin
                m_phase <= 0;
            end
            if (reseed_valid)
                m_lfsr <= (reseed_data == 16'h0000) ? SEED : reseed_data;
            else
                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("shares", 16'(dut_sh()), 16'(m_sh));
            chk("in_ready", 16'(in_ready), 16'(m_phase == 0));
            chk("busy", 16'(busy), 16'(m_phase != 0));
            chk("res_valid", 16'(res_valid), 16'(m_phase == 2));
            chk("res_data", 16'(res_data), 16'(m_data));
            chk("res_err", 16'(res_err), 16'(m_err));
        end
    end

    int acc_q[$];
    int lat;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_shares", 16'(dut_sh()), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        #1 rst_n = 1'b1; in_data = 4'b0101; in_valid = 1'b1;

        // First accept with LFSR at seed value
        @(negedge clk);
        chk("first_shares", 16'(dut_sh()), 16'(11'b01_00_10_00_011));
        chk("first_in_ready", 16'(in_ready), 16'd0);
        chk("first_busy", 16'(busy), 16'd1);
        #1 in_valid = 1'b0; out0 = 1'b1; out1 = 1'b0; out_n0 = 1'b0; out_n1 = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", 16'(res_valid), 16'd0);
        @(negedge clk);
        chk("res_valid_rise", 16'(res_valid), 16'd1);
        chk("res_data_1", 16'(res_data), 16'd1);
        chk("res_err_0", 16'(res_err), 16'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 16'(res_valid), 16'd1);
            chk("hold_data", 16'({res_data, res_err}), 16'b10);
        end
        #1 res_ready = 1'b1;
        @(negedge clk);
        chk("back_idle", 16'({in_ready, res_valid}), 16'b10);

        // Consistency failure: out recombination equals out_n recombination
        #1 res_ready = 1'b0; in_valid = 1'b1; out0 = 1'b1; out1 = 1'b0; out_n0 = 1'b1; out_n1 = 1'b0;
        @(negedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_data", 16'(res_data), 16'd1);
        chk("err_flag", 16'(res_err), 16'd1);
        #1 res_ready = 1'b1;
        @(negedge clk);

        // Reseed to 0x0001 then accept
        #1 res_ready = 1'b0; reseed_valid = 1'b1; reseed_data = 16'h0001;
        @(negedge clk);
        #1 reseed_valid = 1'b0; in_valid = 1'b1; in_data = 4'b0000;
        @(negedge clk);
        chk("reseed1_shares", 16'(dut_sh()), 16'(11'b11_00_00_00_000));
        #1 in_valid = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reseed1_done", 16'(in_ready), 16'd1);

        // Zero reseed falls back to the seed value
        #1 res_ready = 1'b0; reseed_valid = 1'b1; reseed_data = 16'h0000;
        @(negedge clk);
        #1 reseed_valid = 1'b0; in_valid = 1'b1; in_data = 4'b0000;
        @(negedge clk);
        chk("reseed0_shares", 16'(dut_sh()), 16'(11'b11_00_00_00_011));
        #1 in_valid = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-transaction
        #1 res_ready = 1'b0; in_valid = 1'b1; in_data = 4'b1111;
        @(negedge clk);
        #1 in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("abort_valid", 16'(res_valid), 16'd0);
        chk("abort_shares", 16'(dut_sh()), 16'd0);
        chk("abort_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b1; in_data = 4'b1010; out0 = 1'b0; out1 = 1'b1;
        @(negedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        chk("post_reset_latency", 16'(lat), 16'(CL + 1));
        #1 res_ready = 1'b1;
        @(negedge clk);

        // Back-to-back throughput
        #1 in_valid = 1'b1; res_ready = 1'b1; in_data = 4'($urandom);
        for (int i = 0; i < 5 * (CL + 3); i++) begin
            @(negedge clk);
            if (in_ready) acc_q.push_back(i);
            #1 in_data = 4'($urandom); out0 = 1'($urandom); out_n1 = 1'($urandom);
        end
        chk("tput_count_ok", 16'(acc_q.size() >= 4), 16'd1);
        for (int k = 1; k < acc_q.size(); k++)
            chk("tput_gap", 16'(acc_q[k] - acc_q[k-1]), 16'(CL + 3));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            rst_n        = ($urandom_range(0, 299) != 0);
            in_valid     = 1'($urandom);
            in_data      = 4'($urandom);
            res_ready    = 1'($urandom);
            reseed_valid = ($urandom_range(0, 7) == 0);
            reseed_data  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            out0 = 1'($urandom); out1 = 1'($urandom);
            out_n0 = 1'($urandom); out_n1 = 1'($urandom);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mask_share_bridge.md
MASK_SHARE_BRIDGE -- requirements
Module: mask_share_bridge

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, LFSR reset/reload value; SHALL be non-zero.
REQ-002 Parameter CORE_LAT, default 1, register stages between share inputs and the masked core's share outputs (range 1..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  plaintext request valid.
REQ-006 in_ready  out  1  bridge can accept a request.
REQ-007 in_data  in  4  plaintext bits: [0]=a, [1]=b, [2]=c, [3]=d.
REQ-008 reseed_valid  in  1  load reseed_data into the LFSR.
REQ-009 reseed_data  in  16  new LFSR value.
REQ-010 a0,a1,b0,b1,c0,c1,d0,d1  out  1 each  Boolean shares to the masked core.
REQ-011 r0,r1,r2  out  1 each  fresh randomness to the masked core.
REQ-012 out0,out1,out_n0,out_n1  in  1 each  registered share outputs returned from the masked core.
REQ-013 res_valid  out  1  result available; res_ready  in  1  result consumed.
REQ-014 res_data  out  1  recombined result (out0^out1).
REQ-015 res_err  out  1  consistency failure: recombined out equals recombined out_n.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 LFSR: 16-bit Fibonacci, taps 16,14,13,11; next = {l[14:0], l[15]^l[13]^l[12]^l[10]}; advances one step every clock edge outside reset.
REQ-018 reseed_valid SHALL take priority over the advance step; reseed_data of 16'h0000 SHALL load LFSR_SEED instead.
REQ-019 Masks m = l[3:0] and r0=l[4], r1=l[5], r2=l[6], sampled from the pre-edge LFSR value at the accept edge.
REQ-020 At accept: x0 = x ^ m[i], x1 = m[i] for x=a,b,c,d with i=0..3; all eight shares and r0..r2 are registered.
REQ-021 Share and r outputs SHALL hold stable from accept until the next accept, including through IDLE (no return-to-zero).
REQ-022 FSM states IDLE, WAIT, HOLD; in_ready = (state==IDLE).
REQ-023 IDLE: on in_valid, accept, load cnt=CORE_LAT, go to WAIT.
REQ-024 WAIT: if cnt!=0, decrement; if cnt==0, capture res_data=out0^out1 and res_err=~((out0^out1)^(out_n0^out_n1)), go to HOLD.
REQ-025 Latency: res_valid SHALL rise CORE_LAT+1 cycles after the accept edge.
REQ-026 HOLD: res_valid=1; res_data and res_err stable; on res_ready, go to IDLE.
REQ-027 No bypass: after a HOLD handshake, the next accept occurs no earlier than the following edge; peak throughput one request per CORE_LAT+3 cycles.
REQ-028 in_valid outside IDLE SHALL be ignored; res_ready outside HOLD SHALL be ignored.
REQ-029 Reseed while busy SHALL update the LFSR immediately and SHALL NOT alter the in-flight shares or r.
REQ-030 res_data and res_err SHALL hold their last captured values in IDLE and WAIT; res_valid=0 in those states.

Reset
REQ-031 While rst_n=0: state=IDLE, cnt=0, LFSR=LFSR_SEED, all shares and r0..r2 = 0, res_valid=0, res_data=0, res_err=0, busy=0, in_ready=1.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately; the transaction result is never presented.

Verification
REQ-033 Release reset; in_data=4'b0101 with in_valid at the first edge (LFSR=16'hACE1) -> a0=0,a1=1,b0=0,b1=0,c0=1,c1=0,d0=0,d1=0, r0=0,r1=1,r2=1; in_ready=0, busy=1 after the edge.
REQ-034 CORE_LAT=1; core model returns out0=1,out1=0,out_n0=0,out_n1=0 -> res_valid rises 2 cycles after accept, res_data=1, res_err=0; res_ready held low 5 cycles -> outputs stable; res_ready=1 -> IDLE next edge.
REQ-035 Core model returns out0=1,out1=0,out_n0=1,out_n1=0 -> res_data=1, res_err=1.
REQ-036 reseed_valid=1 with reseed_data=16'h0001, accept on the next edge -> m=4'b0001, r0=r1=r2=0; reseed_data=16'h0000 -> LFSR reads 16'hACE1 on the following cycle.
REQ-037 rst_n pulsed low while in WAIT -> res_valid never rises, shares=0, in_ready=1; a new request then completes normally with latency CORE_LAT+1.
REQ-038 in_valid held high continuously, res_ready held high -> accepts spaced exactly CORE_LAT+3 cycles apart; each response matches the model for its own in_data.
